// File: rtl/odiv_pkg.sv
// Shared definitions for the online-division sequencer and the CA register block:
// sequencer state encoding, digit-counter width and default operand sizes.
package odiv_pkg;

  // Width of the digit index and of the CA alignment shift amount.
  localparam int CNT_W = 11;

  // Default operation size, shared with the CA register/RAM generator.
  localparam int ODIV_UNROLLING    = 64;
  localparam int ODIV_ONLINE_DELAY = 3;

  // Sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } odiv_state_t;

endpackage : odiv_pkg

// File: rtl/odiv_digit_counter.sv
// Digit counter for the online-division sequencer.
// Holds the 11-bit digit index and registers the outputs derived from it
// (RAM address, CA shift amount, digit request, quotient-digit valid), so that
// every one of them lines up with the counter value it describes.
module odiv_digit_counter
  import odiv_pkg::*;
#(
  parameter int UNROLLING    = ODIV_UNROLLING,
  parameter int ONLINE_DELAY = ODIV_ONLINE_DELAY,
  parameter int ADDR_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  clear,        // next count is 0
  input  logic                  inc,          // next count is count+1 (ignored when clear)
  input  logic                  run_next,     // next cycle belongs to a RUN
  input  logic                  active_next,  // next cycle is an enabled (unstalled) RUN cycle
  output logic [CNT_W-1:0]      count,
  output logic [ADDR_WIDTH-1:0] accum,
  output logic [CNT_W-1:0]      shift_cnt,
  output logic                  digit_req,
  output logic                  out_valid,
  output logic                  last,         // current count is the final digit index
  output logic                  zero_next     // next count is 0
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(UNROLLING + ONLINE_DELAY - 1);
  localparam logic [CNT_W-1:0] UNROLL   = CNT_W'(UNROLLING);
  localparam logic [CNT_W-1:0] UNROLL_1 = CNT_W'(UNROLLING - 1);
  localparam logic [CNT_W-1:0] DELAY    = CNT_W'(ONLINE_DELAY);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [ADDR_WIDTH-1:0] accum_reg;
  logic [CNT_W-1:0]      shift_cnt_reg;
  logic [CNT_W-1:0]      shift_cnt_next;
  logic                  digit_req_reg;
  logic                  out_valid_reg;

  // Next digit index: clear wins over increment, otherwise hold.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc) begin
      count_next = count_reg + ONE;
    end
  end

  // CA alignment shift counts down from UNROLLING-1 and saturates at 0 once the
  // input digits are exhausted; outside RUN it reads 0.
  always_comb begin
    shift_cnt_next = '0;
    if (run_next && (count_next < UNROLL)) begin
      shift_cnt_next = UNROLL_1 - count_next;
    end
  end

  // Counter and its derived outputs, registered together.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      count_reg     <= '0;
      accum_reg     <= '0;
      shift_cnt_reg <= '0;
      digit_req_reg <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      accum_reg     <= count_next[ADDR_WIDTH-1:0];
      shift_cnt_reg <= shift_cnt_next;
      digit_req_reg <= active_next && (count_next < UNROLL);
      out_valid_reg <= active_next && (count_next >= DELAY);
    end
  end

  assign count     = count_reg;
  assign accum     = accum_reg;
  assign shift_cnt = shift_cnt_reg;
  assign digit_req = digit_req_reg;
  assign out_valid = out_valid_reg;
  assign last      = (count_reg == LAST_CNT);
  assign zero_next = (count_next == '0);

endmodule : odiv_digit_counter

// File: rtl/online_div_seq_ctrl.sv
// Sequencer for one online-division operation.
// Drives the CA register/RAM generator controls (enable, refresh, accum, counter,
// shift_cnt), frames the digit streams (digit_req, out_valid) and provides the
// start/busy/done handshake. All outputs are registered.
// Optional feature macro: ODIV_SEQ_STALL_EN adds a stall input that freezes the
// sequence for as long as it is held; without it RUN lasts exactly
// UNROLLING+ONLINE_DELAY cycles.
// asyn_reset must also reset the CA datapath so both sides restart together.
module online_div_seq_ctrl
  import odiv_pkg::*;
#(
  parameter int UNROLLING    = ODIV_UNROLLING,
  parameter int ONLINE_DELAY = ODIV_ONLINE_DELAY,
  parameter int ADDR_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  start,
  input  logic                  abort,
`ifdef ODIV_SEQ_STALL_EN
  input  logic                  stall,
`endif
  output logic                  enable,
  output logic                  refresh,
  output logic [ADDR_WIDTH-1:0] accum,
  output logic [CNT_W-1:0]      counter,
  output logic [CNT_W-1:0]      shift_cnt,
  output logic                  digit_req,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done
);

  odiv_state_t state_reg;
  odiv_state_t state_next;

  logic enable_reg;
  logic refresh_reg;
  logic busy_reg;
  logic done_reg;

  logic stall_int;
  logic cnt_clear;
  logic cnt_inc;
  logic cnt_last;
  logic cnt_zero_next;
  logic run_next;
  logic active_next;

`ifdef ODIV_SEQ_STALL_EN
  assign stall_int = stall;
`else
  assign stall_int = 1'b0;
`endif

  // Next-state and counter control. The current cycle advances the digit index
  // only when it was enabled; a stalled cycle leaves everything in place.
  always_comb begin
    state_next = state_reg;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (start && !abort) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
          cnt_clear  = 1'b1;
        end else if (enable_reg && cnt_last) begin
          state_next = ST_DONE;
          cnt_clear  = 1'b1;
        end else begin
          cnt_inc = enable_reg;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_clear  = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  // A RUN cycle is enabled unless stall is sampled high at the edge that starts it.
  assign run_next    = (state_next == ST_RUN);
  assign active_next = run_next && !stall_int;

  // Digit index plus its derived outputs.
  odiv_digit_counter #(
    .UNROLLING    (UNROLLING),
    .ONLINE_DELAY (ONLINE_DELAY),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_digit_counter (
    .clk         (clk),
    .asyn_reset  (asyn_reset),
    .clear       (cnt_clear),
    .inc         (cnt_inc),
    .run_next    (run_next),
    .active_next (active_next),
    .count       (counter),
    .accum       (accum),
    .shift_cnt   (shift_cnt),
    .digit_req   (digit_req),
    .out_valid   (out_valid),
    .last        (cnt_last),
    .zero_next   (cnt_zero_next)
  );

  // FSM state and registered control outputs. refresh marks the first enabled
  // cycle at digit 0; stalled cycles at digit 0 simply push it later, and once
  // digit 0 is consumed the index never returns to 0 within the operation.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_reg   <= ST_IDLE;
      enable_reg  <= 1'b0;
      refresh_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      enable_reg  <= active_next;
      refresh_reg <= active_next && cnt_zero_next;
      busy_reg    <= run_next;
      done_reg    <= (state_next == ST_DONE);
    end
  end

  assign enable  = enable_reg;
  assign refresh = refresh_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule : online_div_seq_ctrl

// File: tb/tb_online_div_seq_ctrl.sv
// Testbench for online_div_seq_ctrl (UNROLLING=64, ONLINE_DELAY=3).
// A cycle-level reference model predicts every output vector; predictions are
// queued when stimulus is driven and popped when the DUT outputs are sampled.
// Per-operation totals are also checked against fixed expected numbers.
module tb_online_div_seq_ctrl;
  import odiv_pkg::*;

  localparam int U  = 64;
  localparam int OD = 3;
  localparam int AW = 7;
  localparam int N  = U + OD;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  typedef struct packed {
    logic             enable;
    logic             refresh;
    logic [AW-1:0]    accum;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] shift_cnt;
    logic             digit_req;
    logic             out_valid;
    logic             busy;
    logic             done;
  } obs_t;

  logic clk = 1'b0;
  logic asyn_reset;
  logic start;
  logic abort;
  logic stall;

  logic             enable;
  logic             refresh;
  logic [AW-1:0]    accum;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] shift_cnt;
  logic             digit_req;
  logic             out_valid;
  logic             busy;
  logic             done;

  obs_t obs;
  obs_t exp_v;
  obs_t sb_q[$];

  int errors = 0;
  int checks = 0;

  int m_phase = PH_IDLE;
  int m_cnt   = 0;
  bit m_en    = 1'b0;

  always #5 clk = ~clk;

  online_div_seq_ctrl #(
    .UNROLLING    (U),
    .ONLINE_DELAY (OD),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .start      (start),
    .abort      (abort),
`ifdef ODIV_SEQ_STALL_EN
    .stall      (stall),
`endif
    .enable     (enable),
    .refresh    (refresh),
    .accum      (accum),
    .counter    (counter),
    .shift_cnt  (shift_cnt),
    .digit_req  (digit_req),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always_comb obs = {enable, refresh, accum, counter, shift_cnt, digit_req, out_valid, busy, done};

  // Reference model: outputs of the current cycle.
  function automatic obs_t model_out();
    obs_t o;
    o = '0;
    if (m_phase == PH_RUN) begin
      o.busy      = 1'b1;
      o.counter   = CNT_W'(m_cnt);
      o.accum     = AW'(m_cnt);
      o.shift_cnt = (m_cnt < U) ? CNT_W'(U - 1 - m_cnt) : '0;
      o.enable    = m_en;
      o.digit_req = m_en && (m_cnt < U);
      o.out_valid = m_en && (m_cnt >= OD);
      o.refresh   = m_en && (m_cnt == 0);
    end else if (m_phase == PH_DONE) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  // Reference model: one clock edge with the given inputs.
  task automatic model_step(input bit st, input bit ab, input bit sl);
    case (m_phase)
      PH_IDLE: if (st && !ab) begin
        m_phase = PH_RUN;
        m_cnt   = 0;
        m_en    = !sl;
      end
      PH_RUN: begin
        if (ab) begin
          m_phase = PH_IDLE;
        end else if (m_en && (m_cnt == N - 1)) begin
          m_phase = PH_DONE;
        end else begin
          if (m_en) m_cnt++;
          m_en = !sl;
        end
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_cnt   = 0;
    m_en    = 1'b0;
    sb_q.delete();
  endtask

  // Drive inputs for one edge, queue the model prediction, sample 1 ns after the edge.
  task automatic drive_cycle(input bit st, input bit ab, input bit sl);
    bit sl_eff;
`ifdef ODIV_SEQ_STALL_EN
    sl_eff = sl;
`else
    sl_eff = 1'b0;
`endif
    @(negedge clk);
    start = st;
    abort = ab;
    stall = sl;
    model_step(st, ab, sl_eff);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, obs_t'('0));
    end
    @(negedge clk);
    asyn_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_idle: got %h expected %h", obs, exp_v);
      end
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single_run();
    int run_len = 0, dreq = 0, ov = 0, refr = 0, ref_cnt = -1, done_at = -1;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(i == 0, 1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single_run cycle %0d: got %h expected %h", i + 1, obs, exp_v);
      end
      if (busy) run_len++;
      if (digit_req) dreq++;
      if (out_valid) ov++;
      if (refresh) begin
        refr++;
        ref_cnt = int'(counter);
      end
      if (busy && (counter == 0 || counter == 63 || counter >= 64)) begin
        checks++;
        if (shift_cnt !== ((counter == 0) ? 11'd63 : 11'd0)) begin
          errors++;
          $display("FAIL shift_cnt at counter %0d: got %0d expected %0d", counter, shift_cnt,
                   (counter == 0) ? 63 : 0);
        end
      end
      if (done) begin
        done_at = i + 1;
        break;
      end
    end
    checks++;
    if (run_len != 67) begin
      errors++;
      $display("FAIL run_length: got %0d expected 67", run_len);
    end
    checks++;
    if (dreq != 64) begin
      errors++;
      $display("FAIL digit_req_count: got %0d expected 64", dreq);
    end
    checks++;
    if (ov != 64) begin
      errors++;
      $display("FAIL out_valid_count: got %0d expected 64", ov);
    end
    checks++;
    if (refr != 1 || ref_cnt != 0) begin
      errors++;
      $display("FAIL refresh: got %0d pulses at counter %0d expected 1 at 0", refr, ref_cnt);
    end
    checks++;
    if (done_at != 68) begin
      errors++;
      $display("FAIL done_cycle: got %0d expected 68", done_at);
    end
    drive_cycle(1'b0, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got %h expected %h", obs, exp_v);
    end
    $display("op single_run: run_len=%0d digit_req=%0d out_valid=%0d done_at=%0d", run_len, dreq, ov, done_at);
  endtask

  task automatic test_ignored_start();
    int run_len = 0, done_cnt = 0;
    bit seen_done = 1'b0, restarted = 1'b0, st;
    drive_cycle(1'b1, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ign_start first: got %h expected %h", obs, exp_v);
    end
    run_len = int'(busy);
    for (int i = 0; i < 100 && !restarted; i++) begin
      st = (m_phase == PH_RUN && m_cnt == 10) || (m_phase == PH_DONE) ||
           (m_phase == PH_IDLE && seen_done);
      if (m_phase == PH_IDLE && seen_done) restarted = 1'b1;
      drive_cycle(st, 1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ign_start cycle %0d: got %h expected %h", i, obs, exp_v);
      end
      if (!restarted && busy) run_len++;
      if (done) begin
        done_cnt++;
        seen_done = 1'b1;
      end
    end
    checks++;
    if (!(refresh === 1'b1 && counter === 11'd0 && busy === 1'b1)) begin
      errors++;
      $display("FAIL restart_after_done: got refresh=%b counter=%0d busy=%b expected 1 0 1",
               refresh, counter, busy);
    end
    checks++;
    if (run_len != 67 || done_cnt != 1) begin
      errors++;
      $display("FAIL ign_start_len: got len=%0d done=%0d expected 67 1", run_len, done_cnt);
    end
    for (int i = 0; i < 100 && m_phase != PH_IDLE; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ign_start run2 cycle %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    $display("op ignored_start: first_len=%0d dones=%0d", run_len, done_cnt);
  endtask

  task automatic test_abort();
    int done_cnt = 0, run_len = 0;
    bit ab;
    drive_cycle(1'b1, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    for (int i = 0; i < 100 && m_phase == PH_RUN; i++) begin
      ab = (m_cnt == 20);
      drive_cycle(1'b0, ab, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abort cycle %0d: got %h expected %h", i, obs, exp_v);
      end
      if (ab) begin
        checks++;
        if (obs !== '0) begin
          errors++;
          $display("FAIL abort_clear: got %h expected %h", obs, obs_t'('0));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(i == 1, i == 1, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle cycle %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    drive_cycle(1'b1, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    run_len = int'(busy);
    for (int i = 0; i < 100 && m_phase != PH_IDLE; i++) begin
      ab = (m_phase == PH_DONE);
      drive_cycle(1'b0, ab, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abort_rerun cycle %0d: got %h expected %h", i, obs, exp_v);
      end
      if (busy) run_len++;
      if (done) done_cnt++;
    end
    checks++;
    if (run_len != 67 || done_cnt != 1) begin
      errors++;
      $display("FAIL abort_rerun_len: got len=%0d done=%0d expected 67 1", run_len, done_cnt);
    end
    $display("op abort: rerun_len=%0d dones=%0d", run_len, done_cnt);
  endtask

  task automatic test_async_reset();
    int run_len = 0;
    drive_cycle(1'b1, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    for (int i = 0; i < 100 && m_cnt != 30; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb_q.pop_front();
    end
    checks++;
    if (counter !== 11'd30 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got counter=%0d busy=%b expected 30 1", counter, busy);
    end
    #2;
    asyn_reset = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL areset_async_clear: got %h expected %h", obs, obs_t'('0));
    end
    model_reset();
    @(negedge clk);
    asyn_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL areset_idle: got %h expected %h", obs, exp_v);
      end
    end
    drive_cycle(1'b1, 1'b0, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL areset_restart: got %h expected %h", obs, exp_v);
    end
    run_len = int'(busy);
    for (int i = 0; i < 100 && m_phase != PH_IDLE; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL areset_rerun cycle %0d: got %h expected %h", i, obs, exp_v);
      end
      if (busy) run_len++;
    end
    checks++;
    if (run_len != 67) begin
      errors++;
      $display("FAIL areset_rerun_len: got %0d expected 67", run_len);
    end
    $display("op async_reset: rerun_len=%0d", run_len);
  endtask

`ifdef ODIV_SEQ_STALL_EN
  task automatic test_stall();
    int run_len = 0, en_cnt = 0, refr = 0, ref_at = -1, at40 = 0, s40 = 0;
    bit sl;
    for (int i = 0; i < 200; i++) begin
      sl = (i < 2);
      if (m_phase == PH_RUN && s40 < 5 &&
          ((m_en && m_cnt == 39) || (!m_en && m_cnt == 40))) begin
        sl = 1'b1;
        s40++;
      end
      drive_cycle(i == 0, 1'b0, sl);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stall cycle %0d: got %h expected %h", i + 1, obs, exp_v);
      end
      if (busy) run_len++;
      if (enable) en_cnt++;
      if (busy && counter == 11'd40) at40++;
      if (refresh) begin
        refr++;
        ref_at = i + 1;
      end
      if (m_phase == PH_IDLE) break;
    end
    checks++;
    if (run_len != 74 || en_cnt != 67) begin
      errors++;
      $display("FAIL stall_len: got len=%0d enabled=%0d expected 74 67", run_len, en_cnt);
    end
    checks++;
    if (refr != 1 || ref_at != 3) begin
      errors++;
      $display("FAIL stall_refresh: got %0d pulses at cycle %0d expected 1 at 3", refr, ref_at);
    end
    checks++;
    if (at40 != 6) begin
      errors++;
      $display("FAIL stall_hold40: got %0d cycles at 40 expected 6", at40);
    end
    $display("op stall: run_len=%0d enabled=%0d refresh_at=%0d", run_len, en_cnt, ref_at);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_run();
    test_ignored_start();
    test_abort();
    test_async_reset();
`ifdef ODIV_SEQ_STALL_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_online_div_seq_ctrl
